// File: rtl/sfx_sequencer.sv
// Multi-channel two-step tone sequencer: per-channel IDLE/STEP_A/STEP_B FSMs feed a
// fixed-priority (highest index wins) selector driving a registered divider/volume pair.
module sfx_sequencer #(
  parameter int               NUM_CH      = 4,
  parameter int               DIV_W       = 22,
  parameter int               VOL_W       = 3,
  parameter int               CNT_W       = 29,
  parameter int               STEP_CYCLES = 50_000_000,
  parameter logic [DIV_W-1:0] DIV_MUTE    = '1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       trig,
  input  logic [NUM_CH*DIV_W-1:0] ch_div_a,
  input  logic [NUM_CH*DIV_W-1:0] ch_div_b,
  input  logic [NUM_CH*VOL_W-1:0] ch_vol,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [DIV_W-1:0]        out_div,
  output logic [VOL_W-1:0]        out_vol
);

  typedef enum logic [1:0] {IDLE, STEP_A, STEP_B} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  state_t           state [NUM_CH];
  logic [CNT_W-1:0] cnt   [NUM_CH];
  logic [DIV_W-1:0] sel_div;
  logic [VOL_W-1:0] sel_vol;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (state[i] != IDLE);
    end
  end

  // Later iterations overwrite earlier ones, so the highest busy index wins.
  always_comb begin
    sel_div = DIV_MUTE;
    sel_vol = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state[i] == STEP_A) begin
        sel_div = ch_div_a[i*DIV_W +: DIV_W];
        sel_vol = ch_vol[i*VOL_W +: VOL_W];
      end else if (state[i] == STEP_B) begin
        sel_div = ch_div_b[i*DIV_W +: DIV_W];
        sel_vol = ch_vol[i*VOL_W +: VOL_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      done    <= '0;
      out_div <= DIV_MUTE;
      out_vol <= '0;
    end else begin
      out_div <= sel_div;
      out_vol <= sel_vol;
      for (int i = 0; i < NUM_CH; i++) begin
        done[i] <= 1'b0;
        // enable outranks trig, and trig outranks the end-of-step transition.
        if (!enable) begin
          state[i] <= IDLE;
          cnt[i]   <= '0;
        end else if (trig[i]) begin
          state[i] <= STEP_A;
          cnt[i]   <= '0;
        end else begin
          case (state[i])
            STEP_A: begin
              if (cnt[i] == LAST) begin
                state[i] <= STEP_B;
                cnt[i]   <= '0;
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
            STEP_B: begin
              if (cnt[i] == LAST) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                done[i]  <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
            default: begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule
